// File: rtl/maxpool2d_stream.sv
// Streaming 2x2 stride-2 max-pool over raster-order packed-channel pixels, half-width line buffer.
// Optional fused ReLU on signed samples when MAXPOOL_RELU_EN is defined.
module maxpool2d_stream #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned IN_W     = 6,
  parameter int unsigned IN_H     = 6,
  parameter int unsigned SIGNED   = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic [CHANNELS*DATA_W-1:0] in_data,
  input  logic                       in_valid,
  output logic [CHANNELS*DATA_W-1:0] out_data,
  output logic                       out_valid,
  output logic                       out_last,
  output logic                       frame_done
);

  localparam int unsigned W  = CHANNELS * DATA_W;
  localparam int unsigned OW = IN_W / 2;
  localparam int unsigned OH = IN_H / 2;
  localparam int unsigned CW = $clog2(IN_W);
  localparam int unsigned RW = $clog2(IN_H);
  localparam int unsigned LW = (OW > 1) ? $clog2(OW) : 1;

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [W-1:0]  hreg;
  logic [W-1:0]  linebuf [OW];

  // Per-channel maximum, signedness chosen by parameter.
  function automatic logic [W-1:0] pmax(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0]      r;
    logic [DATA_W-1:0] x;
    logic [DATA_W-1:0] y;
    logic              gt;
    r = '0;
    for (int k = 0; k < int'(CHANNELS); k++) begin
      x = a[k*DATA_W +: DATA_W];
      y = b[k*DATA_W +: DATA_W];
      if (SIGNED != 0) gt = $signed(x) > $signed(y);
      else             gt = x > y;
      r[k*DATA_W +: DATA_W] = gt ? x : y;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] relu(input logic [W-1:0] a);
    logic [W-1:0] r;
    r = a;
`ifdef MAXPOOL_RELU_EN
    for (int k = 0; k < int'(CHANNELS); k++) begin
      if (SIGNED != 0 && a[k*DATA_W + DATA_W - 1]) r[k*DATA_W +: DATA_W] = '0;
    end
`endif
    return r;
  endfunction

  logic          last_col;
  logic          last_row;
  logic          win_col;
  logic          win_row;
  logic [LW-1:0] lb_idx;
  logic [W-1:0]  pair_max;
  logic [W-1:0]  pool_val;

  assign last_col = (col == CW'(IN_W - 1));
  assign last_row = (row == RW'(IN_H - 1));
  assign win_col  = col[0] && (32'(col) < 2 * OW);
  assign win_row  = row[0] && (32'(row) < 2 * OH);
  assign lb_idx   = LW'(col >> 1);
  assign pair_max = pmax(hreg, in_data);
  assign pool_val = relu(pmax(pair_max, linebuf[lb_idx]));

  // Position counters, horizontal holding register and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col        <= '0;
      row        <= '0;
      hreg       <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
      if (clear) begin
        col <= '0;
        row <= '0;
      end else if (in_valid) begin
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
        if (!col[0]) hreg <= in_data;
        if (win_col && win_row) begin
          out_data  <= pool_val;
          out_valid <= 1'b1;
          out_last  <= (row == RW'(2 * OH - 1)) && (col == CW'(2 * OW - 1));
        end
        frame_done <= last_col && last_row;
      end
    end
  end

  // Line buffer is always written on the even row before the odd row reads it.
  always_ff @(posedge clk) begin
    if (!clear && in_valid && win_col && !row[0]) linebuf[lb_idx] <= pair_max;
  end

endmodule

// File: tb/tb_maxpool2d_stream.sv
// Bench for maxpool2d_stream: three configurations checked cycle-by-cycle against a full-frame model.
module tb_maxpool2d_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [2:0]  clr;
  logic [2:0]  vld;
  logic [15:0] din [3];
  logic [15:0] o0;
  logic [7:0]  o1;
  logic [7:0]  o2;
  logic [2:0]  ov;
  logic [2:0]  ol;
  logic [2:0]  ofd;

  int errors = 0;
  int checks = 0;

  maxpool2d_stream #(.DATA_W(8), .CHANNELS(2), .IN_W(4), .IN_H(4), .SIGNED(0)) dut0 (
    .clk(clk), .reset(reset), .clear(clr[0]), .in_data(din[0]), .in_valid(vld[0]),
    .out_data(o0), .out_valid(ov[0]), .out_last(ol[0]), .frame_done(ofd[0]));
  maxpool2d_stream #(.DATA_W(8), .CHANNELS(1), .IN_W(5), .IN_H(5), .SIGNED(0)) dut1 (
    .clk(clk), .reset(reset), .clear(clr[1]), .in_data(din[1][7:0]), .in_valid(vld[1]),
    .out_data(o1), .out_valid(ov[1]), .out_last(ol[1]), .frame_done(ofd[1]));
  maxpool2d_stream #(.DATA_W(8), .CHANNELS(1), .IN_W(4), .IN_H(4), .SIGNED(1)) dut2 (
    .clk(clk), .reset(reset), .clear(clr[2]), .in_data(din[2][7:0]), .in_valid(vld[2]),
    .out_data(o2), .out_valid(ov[2]), .out_last(ol[2]), .frame_done(ofd[2]));

  function automatic int iw(int i); return (i == 1) ? 5 : 4; endfunction
  function automatic int ih(int i); return (i == 1) ? 5 : 4; endfunction
  function automatic int nch(int i); return (i == 0) ? 2 : 1; endfunction
  function automatic bit sg(int i); return i == 2; endfunction

  function automatic logic [15:0] dout(int i);
    if (i == 0) return o0;
    if (i == 1) return {8'h00, o1};
    return {8'h00, o2};
  endfunction

  // Reference model: full frame storage, window max straight from the stored pixels.
  logic [15:0] pix [3][5][5];
  int          mr [3];
  int          mc [3];
  logic        exp_v [3];
  logic        exp_l [3];
  logic        exp_f [3];
  logic [15:0] exp_d [3];
  logic [15:0] got [3][$];
  int          fdcnt [3];

  function automatic bit gt8(bit s, logic [7:0] x, logic [7:0] y);
    return s ? ($signed(x) > $signed(y)) : (x > y);
  endfunction

  function automatic logic [15:0] pool(int i, logic [15:0] a, logic [15:0] b,
                                       logic [15:0] c, logic [15:0] d);
    logic [15:0] w [4];
    logic [15:0] r;
    logic [7:0]  m;
    logic [7:0]  x;
    w[0] = a; w[1] = b; w[2] = c; w[3] = d;
    r = '0;
    for (int ch = 0; ch < nch(i); ch++) begin
      m = w[0][ch*8 +: 8];
      for (int j = 1; j < 4; j++) begin
        x = w[j][ch*8 +: 8];
        if (gt8(sg(i), x, m)) m = x;
      end
`ifdef MAXPOOL_RELU_EN
      if (sg(i) && m[7]) m = 8'h00;
`endif
      r[ch*8 +: 8] = m;
    end
    return r;
  endfunction

  task automatic model_step(int i);
    int r;
    int c;
    exp_v[i] = 1'b0;
    exp_l[i] = 1'b0;
    exp_f[i] = 1'b0;
    if (reset) begin
      mr[i] = 0; mc[i] = 0; exp_d[i] = '0;
    end else if (clr[i]) begin
      mr[i] = 0; mc[i] = 0;
    end else if (vld[i]) begin
      r = mr[i]; c = mc[i];
      pix[i][r][c] = (nch(i) == 1) ? {8'h00, din[i][7:0]} : din[i];
      if (r % 2 == 1 && c % 2 == 1 && r < 2 * (ih(i) / 2) && c < 2 * (iw(i) / 2)) begin
        exp_v[i] = 1'b1;
        exp_d[i] = pool(i, pix[i][r-1][c-1], pix[i][r-1][c], pix[i][r][c-1], pix[i][r][c]);
        exp_l[i] = (r == 2 * (ih(i) / 2) - 1) && (c == 2 * (iw(i) / 2) - 1);
      end
      if (r == ih(i) - 1 && c == iw(i) - 1) exp_f[i] = 1'b1;
      c++;
      if (c == iw(i)) begin
        c = 0; r++;
        if (r == ih(i)) r = 0;
      end
      mr[i] = r; mc[i] = c;
    end
  endtask

  task automatic chk(string nm, int i, logic [15:0] act, logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s inst%0d got=%h exp=%h t=%0t", nm, i, act, req, $time);
    end
  endtask

  // Inputs change on the falling edge; outputs are checked on the following falling edge.
  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 3; i++) model_step(i);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("out_valid", i, 16'(ov[i]), 16'(exp_v[i]));
      chk("out_last", i, 16'(ol[i]), 16'(exp_l[i]));
      chk("frame_done", i, 16'(ofd[i]), 16'(exp_f[i]));
      if (exp_v[i] || reset) chk("out_data", i, dout(i), exp_d[i]);
      if (ov[i]) got[i].push_back(dout(i));
      if (ofd[i]) fdcnt[i]++;
    end
  endtask

  function automatic logic [15:0] pv(int pat, int k);
    if (pat == 0) return 16'(k);
    if (pat == 1) return {8'(15 - k), 8'(k)};
    return 16'h00FD;
  endfunction

  task automatic send_frame(int i, int pat, int gap, int nfr);
    for (int f = 0; f < nfr; f++) begin
      for (int k = 0; k < iw(i) * ih(i); k++) begin
        din[i] = pv(pat, k);
        vld[i] = 1'b1;
        tick();
        if (gap != 0) begin
          vld[i] = 1'b0;
          tick();
        end
      end
    end
    vld[i] = 1'b0;
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic check_got(string nm, int i, logic [15:0] e0, logic [15:0] e1,
                           logic [15:0] e2, logic [15:0] e3, int nfr);
    logic [15:0] e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    chk({nm, "_count"}, i, 16'(got[i].size()), 16'(4 * nfr));
    for (int j = 0; j < got[i].size() && j < 4 * nfr; j++)
      chk({nm, "_value"}, i, got[i][j], e[j % 4]);
    chk({nm, "_frames"}, i, 16'(fdcnt[i]), 16'(nfr));
  endtask

  typedef struct {
    int               inst;
    int               pat;
    int               gap;
    int               nfr;
    logic [3:0][15:0] e;
  } vec_t;

`ifdef MAXPOOL_RELU_EN
  localparam logic [15:0] SEXP = 16'h0000;
`else
  localparam logic [15:0] SEXP = 16'h00FD;
`endif

  vec_t tbl [6];

  initial begin
    tbl[0] = '{inst: 0, pat: 0, gap: 0, nfr: 1, e: {16'd15, 16'd13, 16'd7, 16'd5}};
    tbl[1] = '{inst: 0, pat: 1, gap: 0, nfr: 1, e: {16'h050F, 16'h070D, 16'h0D07, 16'h0F05}};
    tbl[2] = '{inst: 0, pat: 0, gap: 1, nfr: 1, e: {16'd15, 16'd13, 16'd7, 16'd5}};
    tbl[3] = '{inst: 1, pat: 0, gap: 0, nfr: 1, e: {16'd18, 16'd16, 16'd8, 16'd6}};
    tbl[4] = '{inst: 1, pat: 0, gap: 0, nfr: 2, e: {16'd18, 16'd16, 16'd8, 16'd6}};
    tbl[5] = '{inst: 2, pat: 2, gap: 0, nfr: 1, e: {SEXP, SEXP, SEXP, SEXP}};

    reset = 1'b1;
    clr   = '0;
    vld   = '0;
    for (int i = 0; i < 3; i++) begin
      din[i] = '0; mr[i] = 0; mc[i] = 0; fdcnt[i] = 0;
      exp_v[i] = 1'b0; exp_l[i] = 1'b0; exp_f[i] = 1'b0; exp_d[i] = '0;
    end
    idle(2);
    reset = 1'b0;
    idle(2);

    for (int t = 0; t < 6; t++) begin
      got[tbl[t].inst].delete();
      fdcnt[tbl[t].inst] = 0;
      send_frame(tbl[t].inst, tbl[t].pat, tbl[t].gap, tbl[t].nfr);
      idle(3);
      check_got($sformatf("vec%0d", t), tbl[t].inst,
                tbl[t].e[0], tbl[t].e[1], tbl[t].e[2], tbl[t].e[3], tbl[t].nfr);
    end

    // Clear after six pixels, coinciding with a valid pixel that must be dropped.
    for (int k = 0; k < 6; k++) begin
      din[0] = pv(0, k); vld[0] = 1'b1; tick();
    end
    clr[0] = 1'b1; din[0] = 16'h00FF; vld[0] = 1'b1;
    tick();
    clr[0] = 1'b0; vld[0] = 1'b0;
    got[0].delete(); fdcnt[0] = 0;
    send_frame(0, 0, 0, 1);
    idle(3);
    check_got("clear_restart", 0, 16'd5, 16'd7, 16'd13, 16'd15, 1);

    // Same restart, but aborted by reset mid-frame.
    for (int k = 0; k < 6; k++) begin
      din[0] = pv(1, k); vld[0] = 1'b1; tick();
    end
    vld[0] = 1'b0;
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    got[0].delete(); fdcnt[0] = 0;
    send_frame(0, 0, 0, 1);
    idle(3);
    check_got("reset_restart", 0, 16'd5, 16'd7, 16'd13, 16'd15, 1);

    // Random data, valid gaps and occasional clears on every configuration.
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 3; i++) begin
        vld[i] = ($urandom_range(0, 9) < 7);
        clr[i] = ($urandom_range(0, 79) == 0);
        din[i] = 16'($urandom);
      end
      tick();
    end
    clr = '0;
    vld = '0;
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
